cdru_req_stage: RTL

- Per-requester request holding stage that sits directly upstream of the conflict detection read unit.
- Accepts read requests from the three clients (i, d, c) over valid/ready handshakes and holds each request until it is granted.
- Drives the i/d/c enable and address inputs of the conflict unit from registered state.
- Adds age-based anti-starvation, because the conflict unit's fixed priority (i > d > c) can otherwise starve d and c indefinitely.

---
 rtl/cdru_req_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cdru_req_stage.sv
// Request holding stage in front of the conflict detection read unit.
// Holds one request per client (i, d, c) and boosts starved d/c requests.

module cdru_hold_slot #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic          pop_i,
    output logic          req_ready_o,
    output logic          hold_v_o,
    output logic [AW-1:0] hold_a_o
);
    logic          hold_v_q, hold_v_d;
    logic [AW-1:0] hold_a_q, hold_a_d;
    logic          acc;

    // Ready may follow the same-cycle grant so a pop and accept replace the entry.
    assign req_ready_o = ~hold_v_q | pop_i;
    assign acc         = req_valid_i & req_ready_o;

    always_comb begin
        hold_v_d = hold_v_q;
        hold_a_d = hold_a_q;
        if (acc) begin
            hold_v_d = 1'b1;
            hold_a_d = req_addr_i;
        end else if (pop_i) begin
            hold_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_v_q <= 1'b0;
            hold_a_q <= '0;
        end else begin
            hold_v_q <= hold_v_d;
            hold_a_q <= hold_a_d;
        end
    end

    assign hold_v_o = hold_v_q;
    assign hold_a_o = hold_a_q;
endmodule

module cdru_req_stage #(
    parameter int BANKBITS = 5,
    parameter int WORDBITS = 10,
    parameter int STARVE   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req_valid,
    input  logic                         d_req_valid,
    input  logic                         c_req_valid,
    input  logic [BANKBITS+WORDBITS-1:0] i_req_addr,
    input  logic [BANKBITS+WORDBITS-1:0] d_req_addr,
    input  logic [BANKBITS+WORDBITS-1:0] c_req_addr,
    output logic                         i_req_ready,
    output logic                         d_req_ready,
    output logic                         c_req_ready,
    output logic                         i_en,
    output logic                         d_en,
    output logic                         c_en,
    output logic [BANKBITS+WORDBITS-1:0] i_addr,
    output logic [BANKBITS+WORDBITS-1:0] d_addr,
    output logic [BANKBITS+WORDBITS-1:0] c_addr,
    input  logic                         i_grnt,
    input  logic                         d_grnt,
    input  logic                         c_grnt,
    output logic                         busy
);
    localparam int AW   = BANKBITS + WORDBITS;
    localparam int AGEW = $clog2(STARVE + 1);

    logic          hv_i, hv_d, hv_c;
    logic [AW-1:0] ha_i, ha_d, ha_c;
    logic          pop_i, pop_d, pop_c;
    logic [AGEW-1:0] dage_q, dage_d, cage_q, cage_d;
    logic          boost_d, boost_c;

    function automatic logic same_bk(input logic [AW-1:0] a, input logic [AW-1:0] b);
        return a[WORDBITS +: BANKBITS] == b[WORDBITS +: BANKBITS];
    endfunction

    // Saturating count of held-but-not-granted cycles; any pop or empty hold clears it.
    function automatic logic [AGEW-1:0] age_nxt(input logic v, input logic p,
                                                input logic [AGEW-1:0] a);
        if (v && !p) return (a == AGEW'(STARVE)) ? a : a + 1'b1;
        return '0;
    endfunction

    assign pop_i = i_en & i_grnt;
    assign pop_d = d_en & d_grnt;
    assign pop_c = c_en & c_grnt;

    cdru_hold_slot #(.AW(AW)) u_i (
        .clk(clk), .rst(rst), .req_valid_i(i_req_valid), .req_addr_i(i_req_addr),
        .pop_i(pop_i), .req_ready_o(i_req_ready), .hold_v_o(hv_i), .hold_a_o(ha_i));
    cdru_hold_slot #(.AW(AW)) u_d (
        .clk(clk), .rst(rst), .req_valid_i(d_req_valid), .req_addr_i(d_req_addr),
        .pop_i(pop_d), .req_ready_o(d_req_ready), .hold_v_o(hv_d), .hold_a_o(ha_d));
    cdru_hold_slot #(.AW(AW)) u_c (
        .clk(clk), .rst(rst), .req_valid_i(c_req_valid), .req_addr_i(c_req_addr),
        .pop_i(pop_c), .req_ready_o(c_req_ready), .hold_v_o(hv_c), .hold_a_o(ha_c));

    assign dage_d = age_nxt(hv_d, pop_d, dage_q);
    assign cage_d = age_nxt(hv_c, pop_c, cage_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dage_q <= '0;
            cage_q <= '0;
        end else begin
            dage_q <= dage_d;
            cage_q <= cage_d;
        end
    end

    assign boost_d = (dage_q == AGEW'(STARVE));
    assign boost_c = (cage_q == AGEW'(STARVE));

    // Only same-bank competitors of a boosted request are masked; c beats d on a tie.
    assign c_en = hv_c;
    assign d_en = hv_d & ~(boost_c & hv_c & same_bk(ha_d, ha_c));
    assign i_en = hv_i & ~(boost_d & d_en & same_bk(ha_i, ha_d))
                       & ~(boost_c & hv_c & same_bk(ha_i, ha_c));

    assign i_addr = ha_i;
    assign d_addr = ha_d;
    assign c_addr = ha_c;
    assign busy   = hv_i | hv_d | hv_c;
endmodule
